// File: rtl/cpu_to_mem_axi_nx1_arb.sv
// cpu_to_mem_axi_nx1_arb: N-master to 1-slave AXI4 arbiter with independent read and write paths.
// Reads pipeline up to MAX_RD_OUTSTANDING bursts routed back by RID; writes are serialised one at a time.
module cpu_to_mem_axi_nx1_arb #(
  parameter int NUM_MASTERS        = 2,
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 30,
  parameter int STRB_WIDTH         = DATA_WIDTH / 8,
  parameter int ID_WIDTH           = 4,
  parameter int ARB_MODE           = 0,
  parameter int MAX_RD_OUTSTANDING = 4
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [NUM_MASTERS*32-1:0]         m_araddr,
  input  logic [NUM_MASTERS*8-1:0]          m_arlen,
  input  logic [NUM_MASTERS*3-1:0]          m_arsize,
  input  logic [NUM_MASTERS*2-1:0]          m_arburst,
  input  logic [NUM_MASTERS-1:0]            m_arvalid,
  output logic [NUM_MASTERS-1:0]            m_arready,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  output logic [NUM_MASTERS-1:0]            m_rlast,
  input  logic [NUM_MASTERS-1:0]            m_rready,
  input  logic [NUM_MASTERS*32-1:0]         m_awaddr,
  input  logic [NUM_MASTERS*8-1:0]          m_awlen,
  input  logic [NUM_MASTERS*3-1:0]          m_awsize,
  input  logic [NUM_MASTERS*2-1:0]          m_awburst,
  input  logic [NUM_MASTERS-1:0]            m_awvalid,
  output logic [NUM_MASTERS-1:0]            m_awready,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  input  logic [NUM_MASTERS*STRB_WIDTH-1:0] m_wstrb,
  input  logic [NUM_MASTERS-1:0]            m_wlast,
  input  logic [NUM_MASTERS-1:0]            m_wvalid,
  output logic [NUM_MASTERS-1:0]            m_wready,
  output logic [NUM_MASTERS-1:0]            m_bvalid,
  input  logic [NUM_MASTERS-1:0]            m_bready,
  output logic [ID_WIDTH-1:0]               s_axi_arid,
  output logic [ADDR_WIDTH-1:0]             s_axi_araddr,
  output logic [7:0]                        s_axi_arlen,
  output logic [2:0]                        s_axi_arsize,
  output logic [1:0]                        s_axi_arburst,
  output logic                              s_axi_arlock,
  output logic [3:0]                        s_axi_arcache,
  output logic [2:0]                        s_axi_arprot,
  output logic                              s_axi_arvalid,
  input  logic                              s_axi_arready,
  input  logic [ID_WIDTH-1:0]               s_axi_rid,
  input  logic [DATA_WIDTH-1:0]             s_axi_rdata,
  input  logic [1:0]                        s_axi_rresp,
  input  logic                              s_axi_rlast,
  input  logic                              s_axi_rvalid,
  output logic                              s_axi_rready,
  output logic [ID_WIDTH-1:0]               s_axi_awid,
  output logic [ADDR_WIDTH-1:0]             s_axi_awaddr,
  output logic [7:0]                        s_axi_awlen,
  output logic [2:0]                        s_axi_awsize,
  output logic [1:0]                        s_axi_awburst,
  output logic                              s_axi_awlock,
  output logic [3:0]                        s_axi_awcache,
  output logic [2:0]                        s_axi_awprot,
  output logic                              s_axi_awvalid,
  input  logic                              s_axi_awready,
  output logic [DATA_WIDTH-1:0]             s_axi_wdata,
  output logic [STRB_WIDTH-1:0]             s_axi_wstrb,
  output logic                              s_axi_wlast,
  output logic                              s_axi_wvalid,
  input  logic                              s_axi_wready,
  input  logic [ID_WIDTH-1:0]               s_axi_bid,
  input  logic [1:0]                        s_axi_bresp,
  input  logic                              s_axi_bvalid,
  output logic                              s_axi_bready
);
  localparam int N  = NUM_MASTERS;
  localparam int IW = N > 1 ? $clog2(N) : 1;

  typedef enum logic {AR_IDLE, AR_BUSY} ar_state_e;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_W, W_B} wr_state_e;

  function automatic logic [IW-1:0] arb(input logic [N-1:0] req, input logic [IW-1:0] ptr);
    logic found;
    int idx;
    arb = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = ((ARB_MODE == 1 ? 0 : int'(ptr)) + k) % N;
      if (!found && req[idx]) begin
        arb = IW'(idx);
        found = 1'b1;
      end
    end
  endfunction

  function automatic logic [IW-1:0] inc_ptr(input logic [IW-1:0] g);
    inc_ptr = IW'((int'(g) + 1) % N);
  endfunction

  ar_state_e             ar_state_q, ar_state_d;
  logic [IW-1:0]         ar_ptr_q, ar_ptr_d, ar_g_q, ar_g_d, ar_g;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [7:0]            ar_len_q, ar_len_d;
  logic [2:0]            ar_size_q, ar_size_d;
  logic [1:0]            ar_burst_q, ar_burst_d;
  logic [3:0]            rd_cnt_q, rd_cnt_d;
  logic                  ar_hs, r_done;
  int                    ag;

  wr_state_e             wr_state_q, wr_state_d;
  logic [IW-1:0]         aw_ptr_q, aw_ptr_d, wr_o_q, wr_o_d, aw_g;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [7:0]            aw_len_q, aw_len_d;
  logic [2:0]            aw_size_q, aw_size_d;
  logic [1:0]            aw_burst_q, aw_burst_d;
  logic                  aw_grant, in_w, in_b;
  int                    wg, wo;

  always_comb begin
    ar_g       = arb(m_arvalid, ar_ptr_q);
    ag         = int'(ar_g);
    ar_hs      = s_axi_arvalid & s_axi_arready;
    r_done     = s_axi_rvalid & s_axi_rready & s_axi_rlast;
    ar_state_d = ar_state_q;
    ar_ptr_d   = ar_ptr_q;
    ar_g_d     = ar_g_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    if (ar_state_q == AR_IDLE && |m_arvalid && rd_cnt_q < 4'(MAX_RD_OUTSTANDING)) begin
      ar_state_d = AR_BUSY;
      ar_ptr_d   = inc_ptr(ar_g);
      ar_g_d     = ar_g;
      ar_addr_d  = m_araddr[ag*32 +: ADDR_WIDTH];
      ar_len_d   = m_arlen[ag*8 +: 8];
      ar_size_d  = m_arsize[ag*3 +: 3];
      ar_burst_d = m_arburst[ag*2 +: 2];
    end else if (ar_state_q == AR_BUSY && s_axi_arready) begin
      ar_state_d = AR_IDLE;
    end
    rd_cnt_d = rd_cnt_q + 4'(ar_hs) - 4'(r_done);
  end

  assign s_axi_arvalid = ar_state_q == AR_BUSY;
  assign s_axi_arid    = ID_WIDTH'(ar_g_q);
  assign s_axi_araddr  = ar_addr_q;
  assign s_axi_arlen   = ar_len_q;
  assign s_axi_arsize  = ar_size_q;
  assign s_axi_arburst = ar_burst_q;
  assign m_arready     = ar_hs ? N'(1) << ar_g_q : '0;

  // IDs outside the master range are drained so a stray beat cannot stall the slave.
  always_comb begin
    m_rvalid     = '0;
    s_axi_rready = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (s_axi_rid == ID_WIDTH'(i)) begin
        m_rvalid[i]  = s_axi_rvalid & resetn;
        s_axi_rready = m_rready[i];
      end
    end
  end

  assign m_rdata = {N{s_axi_rdata}};
  assign m_rlast = {N{s_axi_rlast}};

  always_comb begin
    aw_g       = arb(m_awvalid, aw_ptr_q);
    wg         = int'(aw_g);
    aw_grant   = wr_state_q == W_IDLE && |m_awvalid;
    wr_state_d = aw_grant ? W_AW :
                 (wr_state_q == W_AW && s_axi_awready) ? W_W :
                 (wr_state_q == W_W && s_axi_wvalid && s_axi_wready && s_axi_wlast) ? W_B :
                 (wr_state_q == W_B && s_axi_bvalid && s_axi_bready) ? W_IDLE : wr_state_q;
    aw_ptr_d   = aw_grant ? inc_ptr(aw_g) : aw_ptr_q;
    wr_o_d     = aw_grant ? aw_g : wr_o_q;
    aw_addr_d  = aw_grant ? m_awaddr[wg*32 +: ADDR_WIDTH] : aw_addr_q;
    aw_len_d   = aw_grant ? m_awlen[wg*8 +: 8] : aw_len_q;
    aw_size_d  = aw_grant ? m_awsize[wg*3 +: 3] : aw_size_q;
    aw_burst_d = aw_grant ? m_awburst[wg*2 +: 2] : aw_burst_q;
  end

  assign wo            = int'(wr_o_q);
  assign in_w          = wr_state_q == W_W;
  assign in_b          = wr_state_q == W_B;
  assign s_axi_awvalid = wr_state_q == W_AW;
  assign s_axi_awid    = ID_WIDTH'(wr_o_q);
  assign s_axi_awaddr  = aw_addr_q;
  assign s_axi_awlen   = aw_len_q;
  assign s_axi_awsize  = aw_size_q;
  assign s_axi_awburst = aw_burst_q;
  assign m_awready     = (s_axi_awvalid & s_axi_awready) ? N'(1) << wr_o_q : '0;
  assign s_axi_wdata   = m_wdata[wo*DATA_WIDTH +: DATA_WIDTH];
  assign s_axi_wstrb   = m_wstrb[wo*STRB_WIDTH +: STRB_WIDTH];
  assign s_axi_wlast   = m_wlast[wo];
  assign s_axi_wvalid  = in_w & m_wvalid[wo];
  assign m_wready      = (in_w & s_axi_wready) ? N'(1) << wr_o_q : '0;
  assign m_bvalid      = (in_b & s_axi_bvalid) ? N'(1) << wr_o_q : '0;
  assign s_axi_bready  = in_b & m_bready[wo];

  assign s_axi_arlock  = 1'b0;
  assign s_axi_arcache = 4'b0;
  assign s_axi_arprot  = 3'b0;
  assign s_axi_awlock  = 1'b0;
  assign s_axi_awcache = 4'b0;
  assign s_axi_awprot  = 3'b0;

  logic unused;
  assign unused = ^{s_axi_rresp, s_axi_bid, s_axi_bresp, m_araddr, m_awaddr};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_state_q <= AR_IDLE;
      ar_ptr_q   <= '0;
      ar_g_q     <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      rd_cnt_q   <= '0;
      wr_state_q <= W_IDLE;
      aw_ptr_q   <= '0;
      wr_o_q     <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
    end else begin
      ar_state_q <= ar_state_d;
      ar_ptr_q   <= ar_ptr_d;
      ar_g_q     <= ar_g_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_state_q <= wr_state_d;
      aw_ptr_q   <= aw_ptr_d;
      wr_o_q     <= wr_o_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
    end
  end
endmodule
